// File: rtl/histogram_median_locator.sv
// Purpose: median X/Y position of a binary frame from its projection histograms.
// Latency: medianValid rises at most BINS+3 cycles after the last bin of the later axis.
// Backpressure: none; bins arriving while a channel is in SCAN or DONE are dropped.
//
// histogram_median_channel
//   One axis. It stores BINS histogram bins in a synchronous-read RAM while
//   summing them. It then walks the RAM from bin 0 until the running sum reaches
//   half the total, and parks in DONE until the parent restarts it.
//   Ports:
//     clk, reset  clock / synchronous active-high reset
//     restart     return to COLLECT with idx/total/cum cleared (clear or commit)
//     binIn       bin value, qualified by binValid
//     binValid    one bin per cycle, ascending from bin 0
//     chanDone    channel is parked in DONE with a result
//     chanBusy    channel is in SCAN or DONE
//     median      median index of the last completed frame
//     empty       last completed frame had a zero total
//
// histogram_median_locator (top)
//   Two channels (X, Y). The result is published once both channels are in DONE.
//   Ports:
//     clk, reset      clock / synchronous active-high reset
//     xHistogramIn    X bin value, qualified by xValid
//     yHistogramIn    Y bin value, qualified by yValid
//     histogramClear  abort both channels and re-arm, outputs hold
//     xMedian         X median, held until the next result
//     yMedian         Y median, held until the next result
//     xEmpty          X total was zero for the last result
//     yEmpty          Y total was zero for the last result
//     medianValid     one-cycle strobe when the four result outputs update
//     busy            either channel is in SCAN or DONE

module histogram_median_channel #(
  parameter int BINS    = 240,
  parameter int BIN_W   = 8,
  parameter int TOTAL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart,
  input  logic [BIN_W-1:0]   binIn,
  input  logic               binValid,
  output logic               chanDone,
  output logic               chanBusy,
  output logic [BIN_W-1:0]   median,
  output logic               empty
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCAN    = 2'd1,
    DONE    = 2'd2
  } chanState_t;

  localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(BINS - 1);

  chanState_t         state, stateNext;
  logic [BIN_W-1:0]   idx, idxNext;
  logic [TOTAL_W-1:0] total, totalNext;
  logic [TOTAL_W-1:0] cum, cumNext;
  logic [TOTAL_W-1:0] half, halfNext;
  logic [BIN_W-1:0]   medianNext;
  logic               emptyNext;
  logic               rdVld, rdVldNext;
  logic               wrEn;
  logic [TOTAL_W-1:0] totalSum;
  logic [TOTAL_W-1:0] cumSum;

  // Bin storage. The read port always follows idx, so during SCAN the data for
  // address idx appears one cycle later alongside rdIdx.
  logic [BIN_W-1:0]   mem [BINS];
  logic [BIN_W-1:0]   rdData;
  logic [BIN_W-1:0]   rdIdx;

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[idx] <= binIn;
    end
    rdData <= mem[idx];
    rdIdx  <= idx;
  end

  assign totalSum = total + TOTAL_W'(binIn);
  assign cumSum   = cum + TOTAL_W'(rdData);

  // Next-state and datapath updates.
  always_comb begin
    stateNext  = state;
    idxNext    = idx;
    totalNext  = total;
    cumNext    = cum;
    halfNext   = half;
    medianNext = median;
    emptyNext  = empty;
    rdVldNext  = 1'b0;
    wrEn       = 1'b0;

    if (restart) begin
      // Abort or acknowledge; the last result stays in median/empty.
      stateNext = COLLECT;
      idxNext   = '0;
      totalNext = '0;
      cumNext   = '0;
    end else begin
      case (state)
        COLLECT: begin
          if (binValid) begin
            wrEn      = 1'b1;
            totalNext = totalSum;
            if (idx == LAST_IDX) begin
              // Ceiling of total/2; total+1 cannot overflow for legal frame sizes.
              halfNext  = (totalSum + TOTAL_W'(1)) >> 1;
              idxNext   = '0;
              stateNext = SCAN;
            end else begin
              idxNext = idx + BIN_W'(1);
            end
          end
        end

        SCAN: begin
          if (total == '0) begin
            // An empty histogram has no meaningful median; report 0 and flag it.
            medianNext = '0;
            emptyNext  = 1'b1;
            stateNext  = DONE;
          end else begin
            rdVldNext = 1'b1;
            // Hold at the last address. The median is found by the last bin
            // anyway, because cum reaches total there and total >= half.
            if (idx != LAST_IDX) begin
              idxNext = idx + BIN_W'(1);
            end
            if (rdVld) begin
              cumNext = cumSum;
              if (cumSum >= half) begin
                medianNext = rdIdx;
                emptyNext  = 1'b0;
                stateNext  = DONE;
                rdVldNext  = 1'b0;
              end
            end
          end
        end

        DONE: begin
          // Park until the parent publishes the pair and restarts both channels.
        end

        default: begin
          stateNext = COLLECT;
          idxNext   = '0;
          totalNext = '0;
          cumNext   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= COLLECT;
      idx    <= '0;
      total  <= '0;
      cum    <= '0;
      half   <= '0;
      median <= '0;
      empty  <= 1'b0;
      rdVld  <= 1'b0;
    end else begin
      state  <= stateNext;
      idx    <= idxNext;
      total  <= totalNext;
      cum    <= cumNext;
      half   <= halfNext;
      median <= medianNext;
      empty  <= emptyNext;
      rdVld  <= rdVldNext;
    end
  end

  assign chanDone = (state == DONE);
  assign chanBusy = (state == SCAN) || (state == DONE);

endmodule

module histogram_median_locator #(
  parameter int X_BINS  = 240,
  parameter int Y_BINS  = 180,
  parameter int BIN_W   = 8,
  parameter int TOTAL_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] xHistogramIn,
  input  logic             xValid,
  input  logic [BIN_W-1:0] yHistogramIn,
  input  logic             yValid,
  input  logic             histogramClear,
  output logic [BIN_W-1:0] xMedian,
  output logic [BIN_W-1:0] yMedian,
  output logic             xEmpty,
  output logic             yEmpty,
  output logic             medianValid,
  output logic             busy
);

  logic             xDone, yDone;
  logic             xBusy, yBusy;
  logic [BIN_W-1:0] xMedChan, yMedChan;
  logic             xEmptyChan, yEmptyChan;
  logic             commit;
  logic             restart;

  // Publish only when both axes are finished. A clear in the same cycle
  // suppresses the result.
  assign commit  = xDone && yDone && !histogramClear;
  assign restart = histogramClear || commit;

  histogram_median_channel #(
    .BINS    (X_BINS),
    .BIN_W   (BIN_W),
    .TOTAL_W (TOTAL_W)
  ) xChannel (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .binIn    (xHistogramIn),
    .binValid (xValid),
    .chanDone (xDone),
    .chanBusy (xBusy),
    .median   (xMedChan),
    .empty    (xEmptyChan)
  );

  histogram_median_channel #(
    .BINS    (Y_BINS),
    .BIN_W   (BIN_W),
    .TOTAL_W (TOTAL_W)
  ) yChannel (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .binIn    (yHistogramIn),
    .binValid (yValid),
    .chanDone (yDone),
    .chanBusy (yBusy),
    .median   (yMedChan),
    .empty    (yEmptyChan)
  );

  // Result outputs are registered. The strobe and the new values appear
  // together, in the same cycle both channels re-enter COLLECT.
  always_ff @(posedge clk) begin
    if (reset) begin
      xMedian     <= '0;
      yMedian     <= '0;
      xEmpty      <= 1'b0;
      yEmpty      <= 1'b0;
      medianValid <= 1'b0;
    end else begin
      medianValid <= commit;
      if (commit) begin
        xMedian <= xMedChan;
        yMedian <= yMedChan;
        xEmpty  <= xEmptyChan;
        yEmpty  <= yEmptyChan;
      end
    end
  end

  assign busy = xBusy || yBusy;

endmodule
